// File: rtl/output_pipe_pkg.sv
// rtl/output_pipe_pkg.sv - shared types and defaults for the output-pipeline fetcher
package output_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ofu_state_e;

  localparam int OUT_BUS_W       = 128;
  localparam int OUT_PIX_W       = 8;
  localparam int OUT_FRAME_WORDS = 19200;

  function automatic int ofu_npix(input int bus_w, input int pix_w);
    return bus_w / pix_w;
  endfunction

endpackage

// File: rtl/ofu_word_fifo.sv
// rtl/ofu_word_fifo.sv - 2-entry FIFO of address-tagged memory words
module ofu_word_fifo #(
  parameter int ADDR_W = 16,
  parameter int BUS_W  = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_tag,
  input  logic [BUS_W-1:0]  push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_tag,
  output logic [BUS_W-1:0]  head_data,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  localparam int ENT_W = ADDR_W + BUS_W;

  logic [ENT_W-1:0] mem_q [2];
  logic [ENT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    // a push into a full FIFO is only legal when the head leaves in the same cycle
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = {push_tag, push_data};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign {head_tag, head_data} = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/output_fetch_unpack.sv
// rtl/output_fetch_unpack.sv - fetches a frame of words from output memory and streams it as pixels
module output_fetch_unpack
  import output_pipe_pkg::*;
#(
  parameter int BUS_W       = OUT_BUS_W,
  parameter int PIX_W       = OUT_PIX_W,
  parameter int ADDR_W      = 16,
  parameter int FRAME_WORDS = OUT_FRAME_WORDS,
  parameter int MEM_LAT     = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              msb_first,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BUS_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic [ADDR_W-1:0] src_addr,
  output logic              busy,
  output logic              frame_done
);

  localparam int NPIX    = ofu_npix(BUS_W, PIX_W);
  localparam int PIX_CW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WORD_CW = $clog2(FRAME_WORDS + 1);
  localparam logic [PIX_CW-1:0]  K_LAST   = PIX_CW'(NPIX - 1);
  localparam logic [WORD_CW-1:0] WORDS_N  = WORD_CW'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0]  LAST_OFS = ADDR_W'(FRAME_WORDS - 1);

  ofu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               msb_q, msb_d;
  logic [WORD_CW-1:0] issued_q, issued_d;
  logic [WORD_CW-1:0] recv_q, recv_d;
  logic [PIX_CW-1:0]  k_q, k_d;
  logic [MEM_LAT-1:0] infl_q, infl_d;

  logic              fifo_flush, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic [ADDR_W-1:0] head_tag, push_tag;
  logic [BUS_W-1:0]  head_data;
  logic [2:0]        occ;
  logic [PIX_CW-1:0] sel;
  logic              xfer;

  assign push_tag = base_q + ADDR_W'(recv_q);

  ofu_word_fifo #(
    .ADDR_W (ADDR_W),
    .BUS_W  (BUS_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_tag  (push_tag),
    .push_data (rd_data),
    .pop       (fifo_pop),
    .head_tag  (head_tag),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    msb_d      = msb_q;
    issued_d   = issued_q;
    recv_d     = recv_q;
    k_d        = k_q;
    infl_d     = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;

    // words held plus reads still in the memory pipe; a new read needs a free slot for each
    occ = {1'b0, fifo_count};
    for (int i = 0; i < MEM_LAT; i++) begin
      occ = occ + {2'b00, infl_q[i]};
    end

    pix_valid = !fifo_empty;
    sel       = msb_q ? (K_LAST - k_q) : k_q;
    pix_data  = pix_valid ? head_data[int'(sel)*PIX_W +: PIX_W] : '0;
    src_addr  = pix_valid ? head_tag : '0;
    pix_last  = pix_valid && (k_q == K_LAST) && ((head_tag - base_q) == LAST_OFS);
    xfer      = pix_valid && pix_ready;

    case (state_q)
      ST_IDLE: begin
        // the first read goes out in the start cycle itself to shorten first-pixel latency
        if (start && !abort) begin
          state_d    = ST_RUN;
          base_d     = base_addr;
          msb_d      = msb_first;
          rd_en      = 1'b1;
          rd_addr    = base_addr;
          issued_d   = WORD_CW'(1);
          recv_d     = '0;
          k_d        = '0;
          fifo_flush = 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if ((issued_q < WORDS_N) && (occ < 3'd2) && !fifo_full) begin
          rd_en    = 1'b1;
          rd_addr  = base_q + ADDR_W'(issued_q);
          issued_d = issued_q + 1'b1;
        end
        if (infl_q[MEM_LAT-1]) begin
          fifo_push = 1'b1;
          recv_d    = recv_q + 1'b1;
        end
        if (xfer) begin
          if (k_q == K_LAST) begin
            k_d      = '0;
            fifo_pop = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
          if (pix_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      rd_en      = 1'b0;
      rd_addr    = '0;
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
    end

    // dropping the in-flight marks makes late read data land nowhere
    infl_d[0] = rd_en;
    for (int i = 1; i < MEM_LAT; i++) begin
      infl_d[i] = infl_q[i-1];
    end
    if (abort) begin
      infl_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      msb_q    <= MSB_FIRST;
      issued_q <= '0;
      recv_q   <= '0;
      k_q      <= '0;
      infl_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      msb_q    <= msb_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      k_q      <= k_d;
      infl_q   <= infl_d;
    end
  end

endmodule

// File: tb/tb_output_fetch_unpack.sv
// tb/tb_output_fetch_unpack.sv - directed bench: latency-1 2-word instance and latency-3 4-word instance
module tb_output_fetch_unpack;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] base_addr = '0;
  logic        msb_first = 1'b0;

  logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic        rd_en_a, valid_a, last_a, busy_a, done_a;
  logic [15:0] rd_addr_a, src_a;
  logic [31:0] rdd_a;
  logic [7:0]  data_a;

  logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic        rd_en_b, valid_b, last_b, busy_b, done_b;
  logic [15:0] rd_addr_b, src_b;
  logic [31:0] p1, p2, p3;
  logic [7:0]  data_b;

  logic [31:0] mem [0:65535];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  output_fetch_unpack #(.BUS_W(32), .PIX_W(8), .ADDR_W(16), .FRAME_WORDS(2), .MEM_LAT(1), .MSB_FIRST(1'b0)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .base_addr(base_addr), .msb_first(msb_first), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rdd_a), .pix_data(data_a), .pix_valid(valid_a), .pix_ready(ready_a),
    .pix_last(last_a), .src_addr(src_a), .busy(busy_a), .frame_done(done_a));

  output_fetch_unpack #(.BUS_W(32), .PIX_W(8), .ADDR_W(16), .FRAME_WORDS(4), .MEM_LAT(3), .MSB_FIRST(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .base_addr(base_addr), .msb_first(msb_first), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(p3), .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b),
    .pix_last(last_b), .src_addr(src_b), .busy(busy_b), .frame_done(done_b));

  // memory models: data is garbage unless a read was issued the right number of cycles earlier
  always @(posedge clock) rdd_a <= rd_en_a ? mem[rd_addr_a] : 32'hBAD0_0000;
  always @(posedge clock) begin
    p1 <= rd_en_b ? mem[rd_addr_b] : 32'hBAD1_0000;
    p2 <= p1;
    p3 <= p2;
  end

  logic [7:0]  qa_data[$], qb_data[$];
  logic [15:0] qa_src[$], qb_src[$], qa_rd[$], qb_rd[$];
  logic        qa_last[$], qb_last[$];
  int          qa_cyc[$];
  int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0;
  int b_iss = 0, b_pop = 0, b_xfer = 0, occ_viol = 0, stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clock) begin
    if (valid_a && ready_a) begin
      qa_data.push_back(data_a);
      qa_src.push_back(src_a);
      qa_last.push_back(last_a);
      qa_cyc.push_back(cyc);
    end
    if (rd_en_a) qa_rd.push_back(rd_addr_a);
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
  end

  always @(negedge clock) begin
    if (prev_stall && (!valid_b || data_b != prev_data)) stall_viol++;
    prev_stall = valid_b && !ready_b;
    prev_data  = data_b;
    if (!busy_b && !rd_en_b) begin
      b_iss = 0; b_pop = 0; b_xfer = 0;
    end
    if (rd_en_b) begin
      if (b_iss - b_pop >= 2) occ_viol++;
      b_iss++;
      qb_rd.push_back(rd_addr_b);
    end
    if (valid_b && ready_b) begin
      qb_data.push_back(data_b);
      qb_src.push_back(src_b);
      qb_last.push_back(last_b);
      if (b_xfer % 4 == 3) b_pop++;
      b_xfer++;
    end
    if (done_b) done_cnt_b++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start_a(input logic [15:0] base, input logic msb, output int s);
    base_addr = base; msb_first = msb; start_a = 1'b1; s = cyc;
    tick();
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b(input logic [15:0] base, input logic msb);
    base_addr = base; msb_first = msb; start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  // expected pixels read left to right from exp; s is the cycle the start pulse was high
  task automatic check_frame_a(input string tag, input int b, input int d, input logic [63:0] exp,
                               input logic [15:0] a0, input int s);
    logic [15:0] ea;
    check({tag, "_count"}, qa_data.size() - b, 8);
    for (int i = 0; i < 8; i++) begin
      ea = (i < 4) ? a0 : a0 + 16'd1;
      check($sformatf("%s_pix%0d", tag, i), qa_data[b+i], exp[8*(7-i) +: 8]);
      check($sformatf("%s_src%0d", tag, i), qa_src[b+i], ea);
      check($sformatf("%s_last%0d", tag, i), qa_last[b+i], i == 7);
      check($sformatf("%s_cyc%0d", tag, i), qa_cyc[b+i], s + 2 + i);
    end
    check({tag, "_done_n"}, done_cnt_a - d, 1);
    check({tag, "_done_cyc"}, done_cyc_a, s + 10);
  endtask

  initial begin
    int s, b, d, r;
    logic [31:0] first4;
    for (int i = 0; i < 65536; i++) mem[i] = {16'hDEAD, i[15:0]};
    mem[16'h0010] = 32'h4433_2211; mem[16'h0011] = 32'h8877_6655;
    mem[16'h0020] = 32'hA3A2_A1A0; mem[16'h0021] = 32'hB3B2_B1B0;
    mem[16'hFFFF] = 32'hDDCC_BBAA; mem[16'h0000] = 32'h0403_0201;
    mem[16'h0040] = 32'h0302_0100; mem[16'h0041] = 32'h0706_0504;
    mem[16'h0042] = 32'h0B0A_0908; mem[16'h0043] = 32'h0F0E_0D0C;

    repeat (3) tick();
    check("rst_a_rd", {rd_en_a, rd_addr_a}, 0);
    check("rst_a_pix", {valid_a, data_a, last_a, src_a}, 0);
    check("rst_a_stat", {busy_a, done_a}, 0);
    check("rst_b_all", {rd_en_b, rd_addr_b, valid_b, data_b, last_b, src_b, busy_b, done_b}, 0);
    reset_n = 1'b1;
    tick();

    // asynchronous reset while pixels are flowing
    pulse_start_a(16'h0010, 1'b0, s);
    tick(); tick();
    check("midrst_busy_before", busy_a, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_outs", {rd_en_a, rd_addr_a, valid_a, data_a, last_a, src_a, busy_a, done_a}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    b = qa_data.size(); d = done_cnt_a;
    pulse_start_a(16'h0010, 1'b0, s);
    repeat (14) tick();
    check_frame_a("lsb", b, d, 64'h1122_3344_5566_7788, 16'h0010, s);
    check("lsb_idle", busy_a, 0);

    b = qa_data.size(); d = done_cnt_a;
    pulse_start_a(16'h0010, 1'b1, s);
    repeat (14) tick();
    check_frame_a("msb", b, d, 64'h4433_2211_8877_6655, 16'h0010, s);

    b = qa_data.size(); d = done_cnt_a; r = qa_rd.size();
    pulse_start_a(16'hFFFF, 1'b0, s);
    repeat (14) tick();
    check("wrap_rd_n", qa_rd.size() - r, 2);
    check("wrap_rd0", qa_rd[r], 16'hFFFF);
    check("wrap_rd1", qa_rd[r+1], 16'h0000);
    check_frame_a("wrap", b, d, 64'hAABB_CCDD_0102_0304, 16'hFFFF, s);

    // abort after three pixels; the pixel handshaken in the abort cycle still counts
    b = qa_data.size(); d = done_cnt_a;
    pulse_start_a(16'h0010, 1'b0, s);
    for (int i = 0; i < 20; i++) begin
      if (qa_data.size() - b >= 3) break;
      tick();
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort_a_busy", busy_a, 0);
    check("abort_a_valid", valid_a, 0);
    repeat (10) tick();
    check("abort_a_count", qa_data.size() - b, 4);
    first4 = 32'h1122_3344;
    for (int i = 0; i < 4; i++) check($sformatf("abort_a_pix%0d", i), qa_data[b+i], first4[8*(3-i) +: 8]);
    check("abort_a_no_done", done_cnt_a - d, 0);

    b = qa_data.size(); d = done_cnt_a;
    pulse_start_a(16'h0020, 1'b0, s);
    repeat (14) tick();
    check_frame_a("restart", b, d, 64'hA0A1_A2A3_B0B1_B2B3, 16'h0020, s);

    // latency-3 instance under a 1,0,0 ready pattern
    b = qb_data.size(); d = done_cnt_b; r = qb_rd.size();
    pulse_start_b(16'h0040, 1'b0);
    for (int i = 0; i < 120; i++) begin
      ready_b = (i % 3 == 0);
      tick();
    end
    ready_b = 1'b1;
    repeat (5) tick();
    check("bp_count", qb_data.size() - b, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("bp_pix%0d", i), qb_data[b+i], i);
      check($sformatf("bp_src%0d", i), qb_src[b+i], 16'h0040 + i / 4);
      check($sformatf("bp_last%0d", i), qb_last[b+i], i == 15);
    end
    check("bp_rd_n", qb_rd.size() - r, 4);
    for (int i = 0; i < 4; i++) check($sformatf("bp_rd%0d", i), qb_rd[r+i], 16'h0040 + i);
    check("bp_done_n", done_cnt_b - d, 1);
    check("bp_occupancy", occ_viol, 0);
    check("bp_stall_hold", stall_viol, 0);

    // abort with reads still in the memory pipe; their data must not surface
    b = qb_data.size(); d = done_cnt_b;
    pulse_start_b(16'h0040, 1'b0);
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    check("abort_b_busy", busy_b, 0);
    check("abort_b_valid", valid_b, 0);
    repeat (10) tick();
    check("abort_b_no_pix", qb_data.size() - b, 0);
    check("abort_b_no_done", done_cnt_b - d, 0);

    b = qb_data.size(); d = done_cnt_b;
    pulse_start_b(16'h0040, 1'b1);
    repeat (40) tick();
    check("msb_b_count", qb_data.size() - b, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("msb_b_pix%0d", i), qb_data[b+i], (i / 4) * 4 + 3 - (i % 4));
      check($sformatf("msb_b_last%0d", i), qb_last[b+i], i == 15);
    end
    check("msb_b_done_n", done_cnt_b - d, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/output_fetch_unpack.md
Name: output_fetch_unpack

Overview:
- Parametrised output-pipeline fetcher. Reads a frame of BUS_W-bit words from output memory, then unpacks each word into PIX_W-bit pixels and streams them out on a valid/ready interface.
- Successor to the fixed 128-bit/8-bit/19200-word fetcher. Adds:
  - downstream backpressure;
  - a pipelined read with a configurable memory latency;
  - a 2-word prefetch buffer;
  - a selectable pixel order;
  - a run-time base address;
  - last-pixel and frame-done indications.
- Sits between the output frame memory and the output formatter/serialiser.

Parameters:
- BUS_W, 128, memory read word width; must be a multiple of PIX_W.
- PIX_W, 8, output pixel width.
- ADDR_W, 16, memory word-address width.
- FRAME_WORDS, 19200, words per frame; must be >= 1 and < 2**ADDR_W.
- MEM_LAT, 1, cycles from rd_en to rd_data valid; allowed range 1..3.
- MSB_FIRST, 0, reset/default pixel order: 0 = bits [PIX_W-1:0] emitted first; 1 = top pixel emitted first.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle, ignored when busy.
- abort  in  1  one-cycle pulse; terminates the frame and returns to idle.
- base_addr  in  ADDR_W  first word address; sampled on start.
- msb_first  in  1  pixel order for this frame; sampled on start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read word address.
- rd_data  in  BUS_W  read data, valid exactly MEM_LAT cycles after rd_en.
- pix_data  out  PIX_W  pixel.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_last  out  1  high with the final pixel of the frame.
- src_addr  out  ADDR_W  word address the current pixel came from.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Derived values: NPIX = BUS_W/PIX_W; a pixel counter of clog2(NPIX) bits (min 1); a word counter of clog2(FRAME_WORDS+1) bits.
- Reset values of all outputs are 0: rd_en, rd_addr, pix_data, pix_valid, pix_last, src_addr, busy, frame_done. The internal buffer and counters are cleared.
- FSM IDLE:
  - on start: latch base_addr and msb_first, clear counters, go to RUN, busy=1.
- FSM RUN, read issue:
  - rd_en=1 when issued_words < FRAME_WORDS and (buffered + in_flight) < 2.
  - rd_addr = base_addr + issued_words, modulo 2**ADDR_W (wrap permitted).
  - Returned words go into a 2-entry FIFO, tagged with their address.
- FSM RUN, unpack:
  - The head FIFO word drives pix_data.
  - Pixel index k (0..NPIX-1) selects slice k when msb_first=0, or slice NPIX-1-k when msb_first=1.
  - A pixel transfers when pix_valid && pix_ready. On transfer k increments; at k = NPIX-1 the head word pops and k returns to 0.
  - pix_valid = FIFO non-empty; pix_data is combinational from the head and k.
  - pix_data and pix_valid must hold stable while pix_valid && !pix_ready.
  - src_addr = tag of the head word.
  - pix_last = pix_valid && k = NPIX-1 && head is word FRAME_WORDS-1.
  - When the last pixel transfers: go to DONE.
- FSM DONE:
  - frame_done=1 for one cycle, busy=0, next state IDLE.
- Throughput: with MEM_LAT=1 and pix_ready held at 1, output is continuous, one pixel per cycle, with no bubbles at word boundaries once the first word arrives.
- First pixel latency: pix_valid rises MEM_LAT+1 cycles after the start pulse.
- abort, accepted in any state:
  - next cycle: IDLE, FIFO flushed, pix_valid=0, busy=0, no frame_done.
  - Data returning from in-flight reads is discarded.
- start while busy: ignored. start together with abort: abort wins.
- FRAME_WORDS=1: exactly one read, NPIX pixels, pix_last on the NPIX-th pixel.
- Downstream stall: the FIFO fills to 2 words, then reads stop. No read is ever issued that could overflow the FIFO, counting in-flight reads.
- Asynchronous reset mid-frame: returns to the reset values; a subsequent start runs a clean frame.

Decomposition:
- Shared package output_pipe_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default constants OUT_BUS_W=128, OUT_PIX_W=8, OUT_FRAME_WORDS=19200;
  - a function computing NPIX.
- One sub-module, ofu_word_fifo: a 2-entry FIFO of {ADDR_W tag, BUS_W data} with push/pop/flush, full/empty and a count output.
- The top level holds the FSM, the issue counter, the in-flight shift register (MEM_LAT deep) and the unpack mux.

Test Plan:
- Pixel order, LSB first: BUS_W=32, PIX_W=8, FRAME_WORDS=2, base=0x0010, mem[0x10]=0x44332211, mem[0x11]=0x88776655, pix_ready=1 -> pixels 11,22,33,44,55,66,77,88 on consecutive cycles; pix_last on 88; src_addr 0x10 then 0x11; frame_done one cycle later.
- Pixel order, MSB first: the same frame with msb_first=1 -> 44,33,22,11,88,77,66,55.
- Backpressure: pix_ready toggled 1,0,0,1... with MEM_LAT=3 -> no pixel lost or duplicated; rd_en never makes FIFO+in-flight exceed 2; pix_data stable during stalls.
- Address wrap: base=0xFFFF, FRAME_WORDS=2 -> rd_addr 0xFFFF then 0x0000.
- Abort mid-frame: abort after 3 pixels -> busy=0 and pix_valid=0 next cycle; no frame_done; a late rd_data is ignored; the next start streams from the new base correctly.
- Default configuration: FRAME_WORDS=19200, base=0x8000 -> 307200 pixels; the last rd_addr is 0xCAFF; exactly one frame_done.
